// File: rtl/string_glyph_sequencer.sv
// Walks a latched string one character at a time and emits one glyph record per character (STRDEC_LINE_WRAP_EN adds line wrap).
// Latency: first record ROM_LATENCY+1 cycles after start; then one record per ROM_LATENCY+2 cycles.
// Backpressure: a record is held stable in EMIT until out_ready; start is ignored while busy.
module string_glyph_sequencer #(
   parameter int STRING_LENGTH = 60,
   parameter int CHAR_ENCODING = 12,
   parameter int DATA_WIDTH    = 24,
   parameter int PAGES         = 2,
   parameter int PNG_W         = 64,
   parameter int PNG_H         = 64,
   parameter int LAST_CHAR     = 383,
   parameter int SUB_CHAR      = 63,
   parameter int ROM_LATENCY   = 1,
   parameter int X_W           = 16,
   parameter int SPACING       = 1
`ifdef STRDEC_LINE_WRAP_EN
   ,
   parameter int LINE_W        = 640
`endif
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          start,
   input  logic [CHAR_ENCODING*STRING_LENGTH-1:0]        str,
   input  logic [STRING_LENGTH*DATA_WIDTH-1:0]           str_color,
   input  logic [$clog2(STRING_LENGTH+1)-1:0]            char_count,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          rom_en,
   output logic [$clog2((LAST_CHAR-31)*6)-1:0]           rom_addr,
   input  logic [5*CHAR_ENCODING-1:0]                    rom_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [$clog2(PAGES*PNG_W*PNG_H)-1:0]          out_pattern_addr,
   output logic [CHAR_ENCODING-1:0]                      out_width,
   output logic [CHAR_ENCODING-1:0]                      out_length,
   output logic [DATA_WIDTH-1:0]                         out_color,
   output logic [X_W-1:0]                                out_x,
   output logic [X_W-1:0]                                out_y,
   output logic [$clog2(STRING_LENGTH)-1:0]              out_index,
   output logic                                          out_last
);

   localparam int CE     = CHAR_ENCODING;
   localparam int IDX_W  = $clog2(STRING_LENGTH);
   localparam int CNT_W  = $clog2(STRING_LENGTH+1);
   localparam int ROM_AW = $clog2((LAST_CHAR-31)*6);
   localparam int PA_W   = $clog2(PAGES*PNG_W*PNG_H);
   localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
   localparam logic [CE+2:0] SIX = 6;

   typedef struct packed {
      logic [CE-1:0] x;
      logic [CE-1:0] y;
      logic [CE-1:0] width;
      logic [CE-1:0] length;
      logic [CE-1:0] page;
   } glyph_meta_t;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [CE-1:0]     str_q   [STRING_LENGTH];
   logic [DATA_WIDTH-1:0] color_q [STRING_LENGTH];
   logic [CNT_W-1:0]  count_q, count_clamped;
   logic [IDX_W-1:0]  index_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CE-1:0]     code, code_sel, code_off;
   logic [CE+2:0]     addr_prod;
   logic              wait_last, last_c;
   glyph_meta_t       meta;
   logic [PA_W-1:0]   pattern_c;
`ifdef STRDEC_LINE_WRAP_EN
   localparam int XW1 = X_W + 1;
   logic [CE-1:0]     line_max;
`endif

   assign meta          = glyph_meta_t'(rom_data);
   assign count_clamped = (char_count > CNT_W'(STRING_LENGTH)) ? CNT_W'(STRING_LENGTH) : char_count;

   // Illegal codes fetch the substitute glyph instead.
   assign code      = str_q[index_q];
   assign code_sel  = (code < CE'(32) || code > CE'(LAST_CHAR)) ? CE'(SUB_CHAR) : code;
   assign code_off  = code_sel - CE'(32);
   assign addr_prod = {3'b000, code_off} * SIX;

   assign wait_last = (wait_q == WAIT_W'(ROM_LATENCY-1));
   assign last_c    = (CNT_W'(index_q) == count_q - 1'b1);
   assign pattern_c = PA_W'(PNG_W) * PA_W'(meta.y) + PA_W'(meta.x)
                    + PA_W'(meta.page) * PA_W'(PNG_W*PNG_H);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      rom_en    = 1'b0;
      rom_addr  = '0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (count_clamped == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            busy     = 1'b1;
            rom_en   = 1'b1;
            rom_addr = ROM_AW'(addr_prod);
            state_d  = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (wait_last) state_d = EMIT;
         end
         EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = out_last ? DONE : ISSUE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q          <= '0;
         index_q          <= '0;
         wait_q           <= '0;
         out_pattern_addr <= '0;
         out_width        <= '0;
         out_length       <= '0;
         out_color        <= '0;
         out_x            <= '0;
         out_y            <= '0;
         out_index        <= '0;
         out_last         <= 1'b0;
         for (int i = 0; i < STRING_LENGTH; i++) begin
            str_q[i]   <= '0;
            color_q[i] <= '0;
         end
`ifdef STRDEC_LINE_WRAP_EN
         line_max <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < STRING_LENGTH; i++) begin
                     str_q[i]   <= str[(STRING_LENGTH-1-i)*CE +: CE];
                     color_q[i] <= str_color[(STRING_LENGTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
                  end
                  count_q <= count_clamped;
                  index_q <= '0;
                  out_x   <= '0;
                  out_y   <= '0;
`ifdef STRDEC_LINE_WRAP_EN
                  line_max <= '0;
`endif
               end
            end
            ISSUE: wait_q <= '0;
            WAIT: begin
               if (wait_last) begin
                  out_pattern_addr <= pattern_c;
                  out_width        <= meta.width;
                  out_length       <= meta.length;
                  out_color        <= color_q[index_q];
                  out_index        <= index_q;
                  out_last         <= last_c;
`ifdef STRDEC_LINE_WRAP_EN
                  // Wrap before the glyph is shown; new line starts below the tallest glyph of the old one.
                  if ({1'b0, out_x} + XW1'(meta.width) > XW1'(LINE_W)) begin
                     out_x    <= '0;
                     out_y    <= out_y + X_W'(line_max) + X_W'(SPACING);
                     line_max <= meta.length;
                  end else if (meta.length > line_max) begin
                     line_max <= meta.length;
                  end
`endif
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_x   <= out_x + X_W'(out_width) + X_W'(SPACING);
                  index_q <= index_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_string_glyph_sequencer.sv
// Directed bench for string_glyph_sequencer: fixed-latency ROM responder plus hand-computed expectations.
module tb_string_glyph_sequencer;

   localparam int SL = 60;
   localparam int CE = 12;
   localparam int DW = 24;
`ifdef STRDEC_LINE_WRAP_EN
   localparam int EXP_X2 = 0;
   int wrap_x [6] = '{0, 9, 0, 9, 0, 9};
   int wrap_y [6] = '{0, 0, 11, 11, 22, 22};
`else
   localparam int EXP_X2 = 18;
`endif

   logic           clk = 1'b0;
   logic           rst, start, out_ready;
   logic [CE*SL-1:0] str;
   logic [SL*DW-1:0] str_color;
   logic [5:0]     char_count;
   logic           busy, done, rom_en, out_valid, out_last;
   logic [11:0]    rom_addr;
   logic [59:0]    rom_data = '0;
   logic [59:0]    rom_word;
   logic [12:0]    out_pattern_addr;
   logic [11:0]    out_width, out_length;
   logic [23:0]    out_color;
   logic [15:0]    out_x, out_y;
   logic [5:0]     out_index;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   string_glyph_sequencer #(
`ifdef STRDEC_LINE_WRAP_EN
      .LINE_W(20),
`endif
      .STRING_LENGTH(SL), .CHAR_ENCODING(CE), .DATA_WIDTH(DW), .ROM_LATENCY(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .str(str), .str_color(str_color),
      .char_count(char_count), .busy(busy), .done(done), .rom_en(rom_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pattern_addr(out_pattern_addr),
      .out_width(out_width), .out_length(out_length), .out_color(out_color),
      .out_x(out_x), .out_y(out_y), .out_index(out_index), .out_last(out_last)
   );

   // One-cycle ROM: data appears the cycle after the strobe.
   always @(posedge clk) if (rom_en) rom_data <= rom_word;
   always @(negedge clk) if (done) done_cnt++;

   function automatic logic [59:0] mk_rom(input int page, input int len, input int wid,
                                          input int y, input int x);
      return {12'(x), 12'(y), 12'(wid), 12'(len), 12'(page)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_char(input int i, input int code, input int col);
      str[(SL-1-i)*CE +: CE]       = CE'(code);
      str_color[(SL-1-i)*DW +: DW] = DW'(col);
   endtask

   task automatic do_start(input int cnt);
      char_count = 6'(cnt);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check("valid_seen", out_valid, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 12);
      check("done_seen", done, 1);
      @(negedge clk);
   endtask

   initial begin
      int n, recs, last_idx;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; char_count = '0;
      str = '0; str_color = '0;
      rom_word = mk_rom(1, 10, 8, 2, 3);
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, recs, last_idx;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; char_count = '0;
      str = '0; str_color = '0;
      rom_word = mk_rom(1, 10, 8, 2, 3);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_rom_en", rom_en, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_pat", out_pattern_addr, 0);
      check("rst_last", out_last, 0);
      rst = 1'b0;
      @(negedge clk);

      // Three legal characters, ready held high.
      set_char(0, 65, 'h111111); set_char(1, 66, 'h222222); set_char(2, 67, 'h333333);
      out_ready = 1'b1;
      do_start(3);
      check("t1_rom_en", rom_en, 1);
      check("t1_busy", busy, 1);
      check("t1_addr_A", rom_addr, 198);
      wait_valid(n);
      check("t1_first_lat", n, 2);
      check("t1_pat", out_pattern_addr, 4227);
      check("t1_width", out_width, 8);
      check("t1_length", out_length, 10);
      check("t1_color0", out_color, 'h111111);
      check("t1_x0", out_x, 0);
      check("t1_y0", out_y, 0);
      check("t1_idx0", out_index, 0);
      check("t1_last0", out_last, 0);
      wait_valid(n);
      check("t1_thru", n, 3);
      check("t1_x1", out_x, 9);
      check("t1_color1", out_color, 'h222222);
      check("t1_idx1", out_index, 1);
      check("t1_last1", out_last, 0);
      wait_valid(n);
      check("t1_x2", out_x, EXP_X2);
      check("t1_idx2", out_index, 2);
      check("t1_last2", out_last, 1);
      @(negedge clk);
      check("t1_done", done, 1);
      check("t1_busy_done", busy, 0);
      check("t1_valid_done", out_valid, 0);
      @(negedge clk);
      check("t1_done_drop", done, 0);
      check("t1_done_cnt", done_cnt, 1);

      // Backpressure, with a start attempt while busy.
      set_char(0, 68, 'hAAAAAA); set_char(1, 69, 'hBBBBBB);
      out_ready = 1'b0;
      do_start(2);
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", out_valid, 1);
         check("t2_hold_color", out_color, 'hAAAAAA);
         check("t2_hold_idx", out_index, 0);
         check("t2_hold_x", out_x, 0);
         check("t2_hold_pat", out_pattern_addr, 4227);
         start      = (i == 1);
         char_count = (i == 1) ? 6'd5 : 6'd2;
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("t2_after_valid", out_valid, 0);
      check("t2_after_x", out_x, 9);
      check("t2_addr_E", rom_addr, 222);
      wait_valid(n);
      check("t2_idx1", out_index, 1);
      check("t2_last1", out_last, 1);
      check("t2_color1", out_color, 'hBBBBBB);
      wait_done();
      check("t2_done_cnt", done_cnt, 2);

      // Illegal codes fetch the substitute glyph.
      set_char(0, 20, 1); set_char(1, 400, 2);
      do_start(2);
      check("t3_addr_20", rom_addr, 186);
      wait_valid(n);
      @(negedge clk);
      check("t3_rom_en", rom_en, 1);
      check("t3_addr_400", rom_addr, 186);
      wait_done();
      check("t3_done_cnt", done_cnt, 3);

      // Empty string.
      do_start(0);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      check("t4_valid", out_valid, 0);
      check("t4_rom_en", rom_en, 0);
      @(negedge clk);
      check("t4_done_drop", done, 0);
      check("t4_done_cnt", done_cnt, 4);

      // Reset during EMIT abandons the string.
      set_char(0, 65, 1); set_char(1, 66, 2); set_char(2, 67, 3);
      out_ready = 1'b0;
      do_start(3);
      wait_valid(n);
      rst = 1'b1;
      @(negedge clk);
      check("t5_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_done_cnt", done_cnt, 4);
      set_char(0, 88, 'hC0FFEE); set_char(1, 89, 5);
      out_ready = 1'b1;
      do_start(2);
      check("t5_addr_X", rom_addr, 336);
      wait_valid(n);
      check("t5_idx0", out_index, 0);
      check("t5_x0", out_x, 0);
      check("t5_color0", out_color, 'hC0FFEE);
      wait_done();
      check("t5_done_cnt2", done_cnt, 5);

      // Oversized count is clamped to the string length.
      for (int i = 0; i < SL; i++) set_char(i, 65, i);
      do_start(63);
      recs = 0;
      last_idx = 0;
      for (int r = 0; r < 70; r++) begin
         wait_valid(n);
         if (!out_valid) break;
         recs++;
         if (out_last) begin
            last_idx = out_index;
            break;
         end
      end
      check("t6_recs", recs, 60);
      check("t6_last_idx", last_idx, 59);
      check("t6_last_color", out_color, 59);
      wait_done();
      check("t6_done_cnt", done_cnt, 6);

`ifdef STRDEC_LINE_WRAP_EN
      for (int i = 0; i < 6; i++) set_char(i, 65, i);
      do_start(6);
      for (int g = 0; g < 6; g++) begin
         wait_valid(n);
         check("t7_wrap_x", out_x, wrap_x[g]);
         check("t7_wrap_y", out_y, wrap_y[g]);
      end
      wait_done();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/string_glyph_sequencer.md
Name: string_glyph_sequencer

Overview:
- Sequential successor to the combinational string decoder.
- On a start pulse it latches a string and its per-character colours, then walks the characters one by one.
- For each character it fetches glyph metadata from the font-descriptor ROM over a fixed-latency read port.
- It emits one glyph record per character (pattern address, size, colour, screen cursor) on a valid/ready stream to the OSD blitter.

Parameters:
- STRING_LENGTH, 60, maximum characters per string.
- CHAR_ENCODING, 12, bits per character code and per ROM metadata field.
- DATA_WIDTH, 24, colour width.
- PAGES, 2, font pattern pages.
- PNG_W, 64, font page width in pixels.
- PNG_H, 64, font page height in pixels.
- LAST_CHAR, 383, highest legal character code (lowest is 32).
- SUB_CHAR, 63, code substituted for illegal characters.
- ROM_LATENCY, 1, cycles from rom_en to valid rom_data (legal range 1..4).
- X_W, 16, cursor width.
- SPACING, 1, pixels added after each glyph.
- LINE_W, 640, wrap width (used only with the feature macro).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle start request.
- str  in  CHAR_ENCODING*STRING_LENGTH  string; character 0 in the MSB field.
- str_color  in  STRING_LENGTH*DATA_WIDTH  colours; character 0 in the MSB field.
- char_count  in  $clog2(STRING_LENGTH+1)  number of characters to emit.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last record is accepted.
- rom_en  out  1  ROM read strobe.
- rom_addr  out  $clog2((LAST_CHAR-31)*6)  (code-32)*6.
- rom_data  in  5*CHAR_ENCODING  fields, LSB up: page, length, width, y, x.
- out_valid  out  1  record valid.
- out_ready  in  1  blitter accepts record.
- out_pattern_addr  out  $clog2(PAGES*PNG_W*PNG_H)  PNG_W*y + x + page*PNG_W*PNG_H.
- out_width  out  CHAR_ENCODING  glyph width.
- out_length  out  CHAR_ENCODING  glyph height.
- out_color  out  DATA_WIDTH  character colour.
- out_x  out  X_W  screen x of the glyph.
- out_y  out  X_W  screen y of the glyph.
- out_index  out  $clog2(STRING_LENGTH)  character position.
- out_last  out  1  final character of the string.

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, internal cursors are 0, latched string is cleared.
- Reset wins over every other input. Reset asserted mid-string abandons the string; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - start=1 latches str, str_color and char_count, clears index, out_x and out_y, and sets busy.
  - Goes to ISSUE, or to DONE if char_count==0.
- start is ignored whenever busy=1.
- char_count > STRING_LENGTH is clamped to STRING_LENGTH.
- ISSUE (1 cycle):
  - rom_en=1; rom_addr=(code-32)*6.
  - code is the character at index, or SUB_CHAR if code<32 or code>LAST_CHAR.
  - Goes to WAIT.
- WAIT (ROM_LATENCY cycles, counter-driven):
  - On the final WAIT edge, rom_data is captured into the output registers.
  - out_pattern_addr arithmetic is done at full output width; products are truncated mod 2^width.
  - Goes to EMIT.
- EMIT:
  - out_valid=1. All out_* fields are held stable until out_valid&&out_ready.
  - On the handshake:
    - out_x += out_width + SPACING (mod 2^X_W).
    - index increments.
    - Goes to ISSUE, or to DONE if out_last.
- out_last=1 when index==char_count-1.
- DONE: done=1 for exactly one cycle, busy falls in the same cycle, then the FSM returns to IDLE.
- Timing with out_ready held at 1: first out_valid appears ROM_LATENCY+1 edges after the start edge. Throughput is one record per ROM_LATENCY+2 cycles.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro STRDEC_LINE_WRAP_EN.
- When defined, before the EMIT of a glyph: if out_x + out_width > LINE_W, then out_x is set to 0 and out_y += previous line's maximum out_length + SPACING.
  - The maximum height is tracked per line and reset at each wrap.
- When not defined, out_y stays 0 and out_x wraps modulo 2^X_W.

Test Plan:
- Reset, then start with char_count=3, str codes 'A','B','C', ROM width=8, ROM_LATENCY=1, out_ready=1:
  - first out_valid appears 2 edges after start;
  - out_x = 0, 9, 18;
  - out_last is set on index 2;
  - done pulses once.
- Backpressure: out_ready low for 5 cycles during EMIT → out_valid stays high and all fields stay stable; the record advances only after out_ready rises.
- Illegal code 20 and code 400 → rom_addr=(63-32)*6=186 for both.
- ROM fields page=1, y=2, x=3 → out_pattern_addr = 64*2 + 3 + 4096 = 4227.
- char_count=0 → done one cycle after start, with no out_valid. A start issued while busy is ignored.
- rst asserted mid-EMIT → next cycle out_valid=0, busy=0, no done. A following start decodes from index 0.
- (STRDEC_LINE_WRAP_EN, LINE_W=20, width 8, height 10, six glyphs):
  - out_x sequence 0, 9, 0, 9, 0, 9;
  - out_y sequence 0, 0, 11, 11, 22, 22.
